// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide single-port RAM with registered address.
// Handles byte/half/word loads with extension, and sub-word stores by read-modify-write.
module mem_access_unit #(
  parameter int BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        ram_wren,
  output logic [29:0] ram_address,
  output logic [31:0] ram_data,
  input  logic [31:0] ram_q
);

  typedef enum logic [1:0] {IDLE, LOAD, MERGE} state_t;

  state_t      state;
  logic [29:0] lat_word;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [15:0] lat_wdata;

  logic        accept;
  logic        misaligned;
  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] merged;
  logic [31:0] load_data;

  always_comb begin
    misaligned = (req_size == 2'd3)
               | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00))
               | ((req_size == 2'd1) & req_addr[0]);
  end

  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  // Big-endian places byte k at physical lane 3-k and half h at lane 1-h.
  assign byte_lane = (BIG_ENDIAN != 0) ? ~lat_off    : lat_off;
  assign half_lane = (BIG_ENDIAN != 0) ? ~lat_off[1] : lat_off[1];
  assign byte_val  = ram_q[{byte_lane, 3'b000} +: 8];
  assign half_val  = ram_q[{half_lane, 4'b0000} +: 16];

  always_comb begin
    merged = ram_q;
    if (lat_size == 2'd0) merged[{byte_lane, 3'b000} +: 8] = lat_wdata[7:0];
    else                  merged[{half_lane, 4'b0000} +: 16] = lat_wdata[15:0];
  end

  always_comb begin
    case (lat_size)
      2'd0:    load_data = {{24{lat_signed & byte_val[7]}}, byte_val};
      2'd1:    load_data = {{16{lat_signed & half_val[15]}}, half_val};
      default: load_data = ram_q;
    endcase
  end

  assign ram_address = (state == IDLE) ? req_addr[31:2] : lat_word;
  assign ram_data    = (state == MERGE) ? merged : req_wdata;
  assign ram_wren    = ~rst & ((state == MERGE)
                     | (accept & req_we & (req_size == 2'd2) & ~misaligned));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      lat_word   <= '0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && req_size == 2'd2) begin
              resp_valid <= 1'b1;
            end else begin
              lat_word   <= req_addr[31:2];
              lat_off    <= req_addr[1:0];
              lat_size   <= req_size;
              lat_signed <= req_signed;
              lat_wdata  <= req_wdata[15:0];
              state      <= req_we ? MERGE : LOAD;
            end
          end
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
          state      <= IDLE;
        end
        MERGE: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: little- and big-endian instances share stimulus,
// each with its own RAM, checked against a byte-addressed memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rdy0, rv0, re0, wren0;
  logic        rdy1, rv1, re1, wren1;
  logic [31:0] rd0, data0, q0;
  logic [31:0] rd1, data1, q1;
  logic [29:0] addr0, addr1;

  logic [31:0] ram0 [256] = '{default: '0};
  logic [31:0] ram1 [256] = '{default: '0};
  logic [7:0]  ra0 = '0, ra1 = '0;
  int          wr_count = 0;

  logic [7:0]  mb0 [1024] = '{default: '0};
  logic [7:0]  mb1 [1024] = '{default: '0};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.BIG_ENDIAN(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0),
    .resp_err(re0), .resp_rdata(rd0), .ram_wren(wren0),
    .ram_address(addr0), .ram_data(data0), .ram_q(q0)
  );

  mem_access_unit #(.BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
    .resp_err(re1), .resp_rdata(rd1), .ram_wren(wren1),
    .ram_address(addr1), .ram_data(data1), .ram_q(q1)
  );

  // RAM: address registered on posedge, q read combinationally from it.
  always @(posedge clk) begin
    if (wren0) ram0[addr0[7:0]] <= data0;
    ra0 <= addr0[7:0];
  end
  always @(posedge clk) begin
    if (wren1) ram1[addr1[7:0]] <= data1;
    ra1 <= addr1[7:0];
  end
  assign q0 = ram0[ra0];
  assign q1 = ram1[ra1];

  always @(posedge clk) if (wren0 || wren1) wr_count <= wr_count + 1;

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd1 && a[0]);
  endfunction

  function automatic logic [31:0] m_load(input int e, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    logic [7:0]  b;
    int          n;
    v = '0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      b = (e == 0) ? mb0[int'(a[9:0]) + i] : mb1[int'(a[9:0]) + i];
      if (e == 0) v = v | (32'(b) << (8 * i));
      else        v = (v << 8) | 32'(b);
    end
    if (sg && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic m_store(input int e, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      if (e == 0) mb0[int'(a[9:0]) + i] = d[8 * i +: 8];
      else        mb1[int'(a[9:0]) + i] = d[8 * (n - 1 - i) +: 8];
    end
  endtask

  function automatic logic [31:0] m_word(input int e, input int w);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (e == 0) v = v | (32'(mb0[4 * w + k]) << (8 * k));
      else        v = v | (32'(mb1[4 * w + k]) << (24 - 8 * k));
    end
    return v;
  endfunction

  // Expected {ready_at_request, latency, {err,rdata} little, {err,rdata} big}.
  function automatic logic [69:0] exp_tuple(input logic we, input logic [1:0] sz,
                                            input logic sg, input logic [31:0] a);
    if (m_mis(sz, a))         return {1'b1, 3'd1, 33'h1_0000_0000, 33'h1_0000_0000};
    if (we && sz == 2'd2)     return {1'b1, 3'd1, 33'h0, 33'h0};
    if (we)                   return {1'b1, 3'd2, 33'h0, 33'h0};
    return {1'b1, 3'd2, 1'b0, m_load(0, a, sz, sg), 1'b0, m_load(1, a, sz, sg)};
  endfunction

  // One request; waits a bounded number of cycles for resp_valid.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [69:0] got);
    int          lat;
    logic        rdy_ok;
    logic [32:0] r0, r1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    rdy_ok = rdy0 & rdy1;
    @(posedge clk);
    lat = -1; r0 = '1; r1 = '1;
    for (int c = 1; c <= 4 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (rv0) begin
        lat = c; r0 = {re0, rd0}; r1 = {re1, rd1};
      end
    end
    got = {rdy_ok, 3'(lat), r0, r1};
  endtask

  task automatic run_op(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [69:0] got, output logic [69:0] exp);
    exp = exp_tuple(we, sz, sg, a);
    do_req(we, sz, sg, a, d, got);
    if (we && !m_mis(sz, a)) begin
      m_store(0, a, sz, d);
      m_store(1, a, sz, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({rv0, re0, rd0, rv1, re1, rd1} !== 68'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {rv0, re0, rd0, rv1, re1, rd1});
    end
    checks++;
    if ({rdy0, rdy1, wren0, wren1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready_wren: got %b want 0000", {rdy0, rdy1, wren0, wren1});
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy0, rdy1, ram0[0], ram1[0]} !== {2'b11, 64'h0}) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", {rdy0, rdy1, ram0[0], ram1[0]}, {2'b11, 64'h0});
    end
  endtask

  task automatic test_sw_lw();
    logic [69:0] got, exp;
    run_op(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, got, exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_word: got %h want %h", got, exp); end
    checks++;
    if ({ram0[16], ram1[16]} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL sw_ram: got %h want deadbeefdeadbeef", {ram0[16], ram1[16]});
    end
    run_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got, exp);
    checks++;
    if (got !== {1'b1, 3'd2, 33'h0_DEAD_BEEF, 33'h0_DEAD_BEEF}) begin
      errors++; $display("FAIL lw_word: got %h want %h", got, {1'b1, 3'd2, 33'h0_DEAD_BEEF, 33'h0_DEAD_BEEF});
    end
  endtask

  task automatic test_byte();
    logic [69:0] got, exp;
    run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, got, exp);
    run_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00A5, got, exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sb_resp: got %h want %h", got, exp); end
    checks++;
    if ({ram0[4], ram1[4]} !== {32'h1122_A544, 32'h11A5_3344}) begin
      errors++; $display("FAIL sb_ram: got %h want 1122a54411a53344", {ram0[4], ram1[4]});
    end
    run_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, got, exp);
    checks++;
    if ({got[64:33], got[31:0]} !== {32'hFFFF_FFA5, 32'hFFFF_FFA5} || got !== exp) begin
      errors++; $display("FAIL lb: got %h want %h", got, exp);
    end
    run_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, got, exp);
    checks++;
    if ({got[64:33], got[31:0]} !== {32'h0000_00A5, 32'h0000_00A5} || got !== exp) begin
      errors++; $display("FAIL lbu: got %h want %h", got, exp);
    end
  endtask

  task automatic test_half();
    logic [69:0] got, exp;
    run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, got, exp);
    run_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8001, got, exp);
    checks++;
    if ({ram0[4], ram1[4]} !== {32'h8001_3344, 32'h1122_8001}) begin
      errors++; $display("FAIL sh_ram: got %h want 80013344_11228001", {ram0[4], ram1[4]});
    end
    run_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, got, exp);
    checks++;
    if ({got[64:33], got[31:0]} !== {32'hFFFF_8001, 32'hFFFF_8001} || got !== exp) begin
      errors++; $display("FAIL lh: got %h want %h", got, exp);
    end
    run_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, got, exp);
    checks++;
    if ({got[64:33], got[31:0]} !== {32'h0000_8001, 32'h0000_8001} || got !== exp) begin
      errors++; $display("FAIL lhu: got %h want %h", got, exp);
    end
  endtask

  task automatic test_misaligned();
    logic [69:0] got, exp;
    int          wc;
    wc = wr_count;
    run_op(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, got, exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lw_misaligned: got %h want %h", got, exp); end
    run_op(1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFF_FFFF, got, exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sh_misaligned: got %h want %h", got, exp); end
    checks++;
    if ({wr_count, rdy0, rdy1, ram0[4], ram0[16]} !== {wc, 2'b11, m_word(0, 4), m_word(0, 16)}) begin
      errors++;
      $display("FAIL misaligned_side_effects: got %h want %h",
               {wr_count, rdy0, rdy1, ram0[4], ram0[16]}, {wc, 2'b11, m_word(0, 4), m_word(0, 16)});
    end
  endtask

  task automatic test_reset_abort();
    logic [69:0] got, exp;
    run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, got, exp);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h0000_00A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({wren0, wren1} !== 2'b11) begin
      errors++; $display("FAIL merge_wren: got %b want 11", {wren0, wren1});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wren0, wren1} !== 2'b00) begin
      errors++; $display("FAIL abort_wren: got %b want 00", {wren0, wren1});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({rv0, rv1, rdy0, rdy1, ram0[4], ram1[4]} !== {4'b0011, m_word(0, 4), m_word(1, 4)}) begin
      errors++;
      $display("FAIL abort_state: got %h want %h", {rv0, rv1, rdy0, rdy1, ram0[4], ram1[4]},
               {4'b0011, m_word(0, 4), m_word(1, 4)});
    end
    @(negedge clk);
    checks++;
    if ({rv0, rv1} !== 2'b00) begin
      errors++; $display("FAIL abort_late_resp: got %b want 00", {rv0, rv1});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [7:0]  ready_seen;
    int          pulses;
    a = $urandom; b = $urandom;
    pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = a;
    ready_seen[0] = rdy0;
    @(negedge clk);
    pulses += int'(rv0);
    ready_seen[1] = rdy0;
    req_addr = 32'h4; req_wdata = b;
    @(negedge clk);
    pulses += int'(rv0);
    ready_seen[2] = rdy0;
    req_we = 1'b0; req_addr = 32'h0;
    @(negedge clk);
    pulses += int'(rv0);
    ready_seen[3] = rdy0;
    req_valid = 1'b0;
    m_store(0, 32'h0, 2'd2, a); m_store(1, 32'h0, 2'd2, a);
    m_store(0, 32'h4, 2'd2, b); m_store(1, 32'h4, 2'd2, b);
    @(negedge clk);
    pulses += int'(rv0);
    checks++;
    if ({rv0, rd0, rv1, rd1} !== {1'b1, a, 1'b1, a}) begin
      errors++; $display("FAIL b2b_lw: got %h want %h", {rv0, rd0, rv1, rd1}, {1'b1, a, 1'b1, a});
    end
    @(negedge clk);
    pulses += int'(rv0);
    checks++;
    if ({pulses, ready_seen[3:0]} !== {32'd3, 4'b0111}) begin
      errors++; $display("FAIL b2b_pulses_ready: got %0d/%b want 3/0111", pulses, ready_seen[3:0]);
    end
    checks++;
    if ({ram0[0], ram0[1], ram1[0], ram1[1]} !== {a, b, a, b}) begin
      errors++; $display("FAIL b2b_ram: got %h want %h", {ram0[0], ram0[1], ram1[0], ram1[1]}, {a, b, a, b});
    end
  endtask

  task automatic test_random();
    logic [69:0] got, exp;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        we;
    int          w;
    for (int i = 0; i < 120; i++) begin
      a  = 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      run_op(we, sz, 1'($urandom_range(0, 1)), a, $urandom, got, exp);
      w = int'(a[9:2]);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_resp[%0d] we=%0d sz=%0d a=%h: got %h want %h", i, we, sz, a, got, exp);
      end
      checks++;
      if ({ram0[w], ram1[w]} !== {m_word(0, w), m_word(1, w)}) begin
        errors++;
        $display("FAIL rand_ram[%0d] word=%0d: got %h want %h", i, w, {ram0[w], ram1[w]},
                 {m_word(0, w), m_word(1, w)});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
